// File: rtl/comb_equiv_sweeper_if.sv
// Bundle between the equivalence sweeper and its environment: stimulus
// vector out to the implementations, their outputs back, plus control and
// verdict signals.
interface comb_equiv_sweeper_if #(
    parameter int IN_W    = 4,
    parameter int NUM_IMP = 4
);
    logic                start;
    logic [IN_W-1:0]     vec;
    logic [NUM_IMP-1:0]  dut_out;
    logic                busy;
    logic                done;
    logic                pass;
    logic [IN_W:0]       mismatch_cnt;
    logic                fail_valid;
    logic [IN_W-1:0]     first_fail_vec;
    logic [NUM_IMP-1:0]  first_fail_bits;

    // Sweeper side.
    modport master (
        input  start, dut_out,
        output vec, busy, done, pass, mismatch_cnt,
               fail_valid, first_fail_vec, first_fail_bits
    );

    // Environment side: drives start and the implementation outputs.
    modport slave (
        output start, dut_out,
        input  vec, busy, done, pass, mismatch_cnt,
               fail_valid, first_fail_vec, first_fail_bits
    );
endinterface

// File: rtl/comb_equiv_sweeper.sv
// Exhaustive-sweep equivalence checker. Walks vec from 0 to all-ones,
// holds each vector HOLD cycles, and on the last cycle of the hold window
// compares every implementation channel against channel 0.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | after reset, waiting for start
// DRIVE | sweeping; vec presented, hold_cnt counts the settle window
// DONE  | verdict valid and held; start restarts the sweep
module comb_equiv_sweeper #(
    parameter int IN_W         = 4,
    parameter int NUM_IMP      = 4,
    parameter int HOLD         = 5,
    parameter int STOP_ON_FAIL = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    comb_equiv_sweeper_if.master bus
);
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

    typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

    state_t              state_q, state_d;
    logic [IN_W-1:0]     vec_q;
    logic [HW-1:0]       hold_cnt;
    logic                busy_q, done_q, pass_q, fv_q;
    logic [IN_W:0]       cnt_q, cnt_next;
    logic [IN_W-1:0]     fvec_q;
    logic [NUM_IMP-1:0]  fbits_q, diff;
    logic                mismatch, cmp_edge, finish, start_sweep;

    // Compare decode and next-state selection.
    always_comb begin
        state_d     = state_q;
        diff        = bus.dut_out ^ {NUM_IMP{bus.dut_out[0]}};
        mismatch    = |diff;
        cmp_edge    = (state_q == DRIVE) && (hold_cnt == HOLD_LAST);
        finish      = cmp_edge &&
                      ((&vec_q) || ((STOP_ON_FAIL != 0) && mismatch));
        cnt_next    = mismatch ? cnt_q + (IN_W+1)'(1) : cnt_q;
        start_sweep = (state_q != DRIVE) && bus.start;
        case (state_q)
            IDLE:    if (bus.start) state_d = DRIVE;
            DRIVE:   if (finish)    state_d = DONE;
            DONE:    if (bus.start) state_d = DRIVE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Sweep datapath: vector/hold counters and verdict statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q    <= '0;
            hold_cnt <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            cnt_q    <= '0;
            fv_q     <= 1'b0;
            fvec_q   <= '0;
            fbits_q  <= '0;
        end else if (start_sweep) begin
            vec_q    <= '0;
            hold_cnt <= '0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            cnt_q    <= '0;
            fv_q     <= 1'b0;
            fvec_q   <= '0;
            fbits_q  <= '0;
        end else if (state_q == DRIVE) begin
            if (cmp_edge) begin
                hold_cnt <= '0;
                cnt_q    <= cnt_next;
                if (mismatch && !fv_q) begin
                    fv_q    <= 1'b1;
                    fvec_q  <= vec_q;
                    fbits_q <= diff;
                end
                if (finish) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    pass_q <= (cnt_next == '0);
                end else begin
                    vec_q <= vec_q + IN_W'(1);
                end
            end else begin
                hold_cnt <= hold_cnt + HW'(1);
            end
        end
    end

    assign bus.vec             = vec_q;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.pass            = pass_q;
    assign bus.mismatch_cnt    = cnt_q;
    assign bus.fail_valid      = fv_q;
    assign bus.first_fail_vec  = fvec_q;
    assign bus.first_fail_bits = fbits_q;
endmodule
